// File: rtl/mcc_pkg.sv
// mcc_pkg: shared definitions for the multi-cycle control unit.
//   state_t          - controller state encoding (also visible on the debug port)
//   OP_*             - supported 6-bit opcodes
//   PCSRC_* / SRCB_* / ALUOP_* - datapath mux and ALU operation encodings
//   CAUSE_*          - trap cause codes
package mcc_pkg;

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EX   = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive memory wait cycles.
//   CLK, RSTn  - clock, asynchronous active-low reset
//   i_clear    - zero the count (state change or not waiting on memory)
//   i_count    - this cycle is a wait cycle (memory state, mem_ready=0)
//   o_expired  - this wait cycle is the MEM_TIMEOUT-th consecutive one
// MEM_TIMEOUT=0 disables expiry.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // r_cnt holds the number of earlier wait cycles, so the current wait
  // cycle is the last allowed one when r_cnt equals MEM_TIMEOUT-1.
  localparam logic [TW-1:0] LAST = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)        r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_count) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (MEM_TIMEOUT != 0) && i_count && (r_cnt == LAST);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: Moore controller sequencing fetch/decode/execute/memory/
// write-back for the MIPS-subset multi-cycle core.
//   CLK, RSTn    - clock, asynchronous active-low reset
//   OPCode       - instruction register [31:26], used only in DECODE
//   mem_ready    - memory completes the current access this cycle
//   PCWr ... ALUSrcA, PCSrc, ALUSrcB, ALUOP - datapath controls
//   retired      - completed-instruction count (wraps)
//   trap         - high while in TRAP; trap_cause holds the first cause
//   o_dbg_state  - current state for observation
// Memory handshake: in FETCH, MEM_READ and MEM_WRITE the request is held
// (controls stay asserted) every cycle; the access completes, and the state
// advances, on the first cycle mem_ready=1. Too many consecutive waits trap.
module multi_cycle_ctrl
  import mcc_pkg::*;
#(
  parameter int OP_W        = 6,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [OP_W-1:0]  OPCode,
  input  logic             mem_ready,
  output logic             PCWr,
  output logic             PCWrCond,
  output logic             IorD,
  output logic             MemRd,
  output logic             MemWr,
  output logic             IRWr,
  output logic             MemtoReg,
  output logic             RegWr,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOP,
  output logic [CNT_W-1:0] retired,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [3:0]       o_dbg_state
);

  state_t           r_state, w_next;
  logic             r_is_load;  // lw vs sw, captured in DECODE for MEM_ADDR
  logic [CNT_W-1:0] r_retired;
  logic [1:0]       r_trap_cause;
  logic             w_in_mem, w_count, w_clear, w_expired;

  assign w_in_mem = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                    (r_state == S_MEM_WRITE);
  assign w_count  = w_in_mem && !mem_ready;
  assign w_clear  = (w_next != r_state) || !w_in_mem;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .i_clear   (w_clear),
    .i_count   (w_count),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= S_START;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START:  w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
                else if (w_expired) w_next = S_TRAP;
      S_DECODE: begin
        if (OPCode == OP_W'(OP_LW) || OPCode == OP_W'(OP_SW)) w_next = S_MEM_ADDR;
        else if (OPCode == OP_W'(OP_RTYPE)) w_next = S_EXEC_R;
        else if (OPCode == OP_W'(OP_BEQ))   w_next = S_BRANCH;
        else if (OPCode == OP_W'(OP_J))     w_next = S_JUMP;
        else if (OPCode == OP_W'(OP_ADDI))  w_next = S_ADDI_EX;
        else                                w_next = S_TRAP;
      end
      S_MEM_ADDR:  w_next = r_is_load ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
                   else if (w_expired) w_next = S_TRAP;
      S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;
                   else if (w_expired) w_next = S_TRAP;
      S_EXEC_R:    w_next = S_R_WB;
      S_ADDI_EX:   w_next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_next = S_FETCH;
      S_TRAP:      w_next = S_TRAP;
      default:     w_next = S_START;
    endcase
  end

  always_comb begin
    PCWr = 1'b0; PCWrCond = 1'b0; IorD = 1'b0; MemRd = 1'b0; MemWr = 1'b0;
    IRWr = 1'b0; MemtoReg = 1'b0; RegWr = 1'b0; RegDst = 1'b0; ALUSrcA = 1'b0;
    PCSrc = PCSRC_ALU; ALUSrcB = SRCB_REG; ALUOP = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        MemRd = 1'b1; ALUSrcB = SRCB_FOUR;
        IRWr = mem_ready; PCWr = mem_ready;
      end
      S_DECODE:              ALUSrcB = SRCB_IMM_SH2;
      S_MEM_ADDR, S_ADDI_EX: begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
      S_MEM_READ:            begin MemRd = 1'b1; IorD = 1'b1; end
      S_MEM_WB:              begin RegWr = 1'b1; MemtoReg = 1'b1; end
      S_MEM_WRITE:           begin MemWr = 1'b1; IorD = 1'b1; end
      S_EXEC_R:              begin ALUSrcA = 1'b1; ALUOP = ALUOP_FUNCT; end
      S_R_WB:                begin RegWr = 1'b1; RegDst = 1'b1; end
      S_BRANCH: begin
        ALUSrcA = 1'b1; ALUOP = ALUOP_SUB; PCWrCond = 1'b1; PCSrc = PCSRC_ALUOUT;
      end
      S_JUMP:                begin PCWr = 1'b1; PCSrc = PCSRC_JUMP; end
      S_ADDI_WB:             RegWr = 1'b1;
      default: ;
    endcase
  end

  // An instruction retires when any state other than START or FETCH itself
  // hands over to FETCH. The first cause entering TRAP is kept.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_retired    <= '0;
      r_trap_cause <= CAUSE_NONE;
      r_is_load    <= 1'b0;
    end else begin
      if (w_next == S_FETCH && r_state != S_START && r_state != S_FETCH)
        r_retired <= r_retired + 1'b1;
      if (w_next == S_TRAP && r_state != S_TRAP)
        r_trap_cause <= (r_state == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      if (r_state == S_DECODE)
        r_is_load <= (OPCode == OP_W'(OP_LW));
    end
  end

  assign retired     = r_retired;
  assign trap        = (r_state == S_TRAP);
  assign trap_cause  = r_trap_cause;
  assign o_dbg_state = r_state;

endmodule
